// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Grant encodings are one-hot per master, all-zero when the bus is idle.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_timeout_watchdog.sv
// Bus-stall watchdog: counts cycles with an active request and no slave response,
// and fires once the count reaches TIMEOUT_CYCLES (0 disables it).
module wb_timeout_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic resp,
  input  logic clear,
  output logic fire
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst, active, resp, clear};
      assign fire = 1'b0;
    end else begin : g_on
      logic [CW-1:0] count_reg;

      // A response in the limit cycle wins over the timeout.
      assign fire = active && !resp && (count_reg == CW'(TIMEOUT_CYCLES));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_reg <= '0;
        end else if (clear || !active || resp || fire) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter_2.sv
// Two-master round-robin Wishbone arbiter with cycle-locked grants and a
// watchdog that aborts stalled transfers with err.
module wb_arbiter_2
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wb_m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_m0_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_m0_dat_o,
  input  logic                    wb_m0_we_i,
  input  logic                    wb_m0_stb_i,
  input  logic                    wb_m0_cyc_i,
  input  logic [SELECT_WIDTH-1:0] wb_m0_sel_i,
  output logic                    wb_m0_ack_o,
  output logic                    wb_m0_err_o,
  output logic                    wb_m0_rty_o,
  input  logic [ADDR_WIDTH-1:0]   wb_m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_m1_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_m1_dat_o,
  input  logic                    wb_m1_we_i,
  input  logic                    wb_m1_stb_i,
  input  logic                    wb_m1_cyc_i,
  input  logic [SELECT_WIDTH-1:0] wb_m1_sel_i,
  output logic                    wb_m1_ack_o,
  output logic                    wb_m1_err_o,
  output logic                    wb_m1_rty_o,
  output logic [ADDR_WIDTH-1:0]   wb_s_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_s_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_s_dat_i,
  output logic                    wb_s_we_o,
  output logic                    wb_s_stb_o,
  output logic                    wb_s_cyc_o,
  output logic [SELECT_WIDTH-1:0] wb_s_sel_o,
  input  logic                    wb_s_ack_i,
  input  logic                    wb_s_err_i,
  input  logic                    wb_s_rty_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  arb_state_t state_reg, state_next;
  logic       last_grant_reg, last_grant_next;
  logic [1:0] grant_reg, grant_next;
  logic       arb_en;
  logic       active, resp, fire;

  // Arbitration only happens when idle or when the owner has dropped cyc.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    arb_en = (state_reg == ARB_IDLE) ||
             (state_reg == ARB_GRANT0 && !wb_m0_cyc_i) ||
             (state_reg == ARB_GRANT1 && !wb_m1_cyc_i);
    if (arb_en) begin
      if (wb_m0_cyc_i && (!wb_m1_cyc_i || last_grant_reg)) begin
        state_next      = ARB_GRANT0;
        last_grant_next = 1'b0;
        grant_next      = GRANT_M0;
      end else if (wb_m1_cyc_i) begin
        state_next      = ARB_GRANT1;
        last_grant_next = 1'b1;
        grant_next      = GRANT_M1;
      end else begin
        state_next = ARB_IDLE;
        grant_next = GRANT_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= GRANT_NONE;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
    end
  end

  assign active = (state_reg == ARB_GRANT0) ? (wb_m0_cyc_i && wb_m0_stb_i) :
                  (state_reg == ARB_GRANT1) ? (wb_m1_cyc_i && wb_m1_stb_i) : 1'b0;
  assign resp   = wb_s_ack_i || wb_s_err_i || wb_s_rty_i;

  wb_timeout_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .active(active),
    .resp  (resp),
    .clear (state_next != state_reg),
    .fire  (fire)
  );

  always_comb begin
    wb_s_adr_o  = '0;
    wb_s_dat_o  = '0;
    wb_s_sel_o  = '0;
    wb_s_we_o   = 1'b0;
    wb_s_stb_o  = 1'b0;
    wb_s_cyc_o  = 1'b0;
    wb_m0_ack_o = 1'b0;
    wb_m0_err_o = 1'b0;
    wb_m0_rty_o = 1'b0;
    wb_m1_ack_o = 1'b0;
    wb_m1_err_o = 1'b0;
    wb_m1_rty_o = 1'b0;
    unique case (state_reg)
      ARB_GRANT0: begin
        wb_s_adr_o  = wb_m0_adr_i;
        wb_s_dat_o  = wb_m0_dat_i;
        wb_s_sel_o  = wb_m0_sel_i;
        wb_s_we_o   = wb_m0_we_i;
        wb_s_stb_o  = wb_m0_stb_i && !fire;
        wb_s_cyc_o  = wb_m0_cyc_i && !fire;
        wb_m0_ack_o = wb_s_ack_i;
        wb_m0_err_o = wb_s_err_i || fire;
        wb_m0_rty_o = wb_s_rty_i;
      end
      ARB_GRANT1: begin
        wb_s_adr_o  = wb_m1_adr_i;
        wb_s_dat_o  = wb_m1_dat_i;
        wb_s_sel_o  = wb_m1_sel_i;
        wb_s_we_o   = wb_m1_we_i;
        wb_s_stb_o  = wb_m1_stb_i && !fire;
        wb_s_cyc_o  = wb_m1_cyc_i && !fire;
        wb_m1_ack_o = wb_s_ack_i;
        wb_m1_err_o = wb_s_err_i || fire;
        wb_m1_rty_o = wb_s_rty_i;
      end
      default: ;
    endcase
  end

  // Read data is broadcast, but held at zero during reset like every other output.
  assign wb_m0_dat_o = rst ? '0 : wb_s_dat_i;
  assign wb_m1_dat_o = rst ? '0 : wb_s_dat_i;
  assign grant_o     = grant_reg;
  assign timeout_o   = fire;

endmodule

// File: tb/tb_wb_arbiter_2.sv
// Directed self-checking bench for wb_arbiter_2; a second instance with the
// watchdog disabled shares the stimulus to show an indefinite stall.
module tb_wb_arbiter_2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat_i;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [3:0]  m0_sel, m1_sel;
  logic        s_ack, s_err, s_rty;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr, s_dat_o;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic        s_we, s_stb, s_cyc, timeout;
  logic [3:0]  s_sel;
  logic [1:0]  grant;

  logic [31:0] z_m0_dat_o, z_m1_dat_o, z_s_adr, z_s_dat_o;
  logic        z_m0_ack, z_m0_err, z_m0_rty, z_m1_ack, z_m1_err, z_m1_rty;
  logic        z_s_we, z_s_stb, z_s_cyc, z_timeout;
  logic [3:0]  z_s_sel;
  logic [1:0]  z_grant;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_arbiter_2 #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .wb_m0_adr_i(m0_adr), .wb_m0_dat_i(m0_dat), .wb_m0_dat_o(m0_dat_o),
    .wb_m0_we_i(m0_we), .wb_m0_stb_i(m0_stb), .wb_m0_cyc_i(m0_cyc), .wb_m0_sel_i(m0_sel),
    .wb_m0_ack_o(m0_ack), .wb_m0_err_o(m0_err), .wb_m0_rty_o(m0_rty),
    .wb_m1_adr_i(m1_adr), .wb_m1_dat_i(m1_dat), .wb_m1_dat_o(m1_dat_o),
    .wb_m1_we_i(m1_we), .wb_m1_stb_i(m1_stb), .wb_m1_cyc_i(m1_cyc), .wb_m1_sel_i(m1_sel),
    .wb_m1_ack_o(m1_ack), .wb_m1_err_o(m1_err), .wb_m1_rty_o(m1_rty),
    .wb_s_adr_o(s_adr), .wb_s_dat_o(s_dat_o), .wb_s_dat_i(s_dat_i),
    .wb_s_we_o(s_we), .wb_s_stb_o(s_stb), .wb_s_cyc_o(s_cyc), .wb_s_sel_o(s_sel),
    .wb_s_ack_i(s_ack), .wb_s_err_i(s_err), .wb_s_rty_i(s_rty),
    .grant_o(grant), .timeout_o(timeout)
  );

  wb_arbiter_2 #(.TIMEOUT_CYCLES(0)) dut_nowd (
    .clk(clk), .rst(rst),
    .wb_m0_adr_i(m0_adr), .wb_m0_dat_i(m0_dat), .wb_m0_dat_o(z_m0_dat_o),
    .wb_m0_we_i(m0_we), .wb_m0_stb_i(m0_stb), .wb_m0_cyc_i(m0_cyc), .wb_m0_sel_i(m0_sel),
    .wb_m0_ack_o(z_m0_ack), .wb_m0_err_o(z_m0_err), .wb_m0_rty_o(z_m0_rty),
    .wb_m1_adr_i(m1_adr), .wb_m1_dat_i(m1_dat), .wb_m1_dat_o(z_m1_dat_o),
    .wb_m1_we_i(m1_we), .wb_m1_stb_i(m1_stb), .wb_m1_cyc_i(m1_cyc), .wb_m1_sel_i(m1_sel),
    .wb_m1_ack_o(z_m1_ack), .wb_m1_err_o(z_m1_err), .wb_m1_rty_o(z_m1_rty),
    .wb_s_adr_o(z_s_adr), .wb_s_dat_o(z_s_dat_o), .wb_s_dat_i(s_dat_i),
    .wb_s_we_o(z_s_we), .wb_s_stb_o(z_s_stb), .wb_s_cyc_o(z_s_cyc), .wb_s_sel_o(z_s_sel),
    .wb_s_ack_i(s_ack), .wb_s_err_i(s_err), .wb_s_rty_i(s_rty),
    .grant_o(z_grant), .timeout_o(z_timeout)
  );

  task automatic idle_inputs();
    m0_adr = '0; m0_dat = '0; m0_we = 0; m0_stb = 0; m0_cyc = 0; m0_sel = '0;
    m1_adr = '0; m1_dat = '0; m1_we = 0; m1_stb = 0; m1_cyc = 0; m1_sel = '0;
    s_ack = 0; s_err = 0; s_rty = 0; s_dat_i = '0;
  endtask

  task automatic settle_idle();
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    s_dat_i = 32'h1234_5678; m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1111_0000;
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got=%b exp=00", grant); end
    n_checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin n_fail++; $display("FAIL reset_s_ctl got=%b exp=000", {s_cyc, s_stb, s_we}); end
    n_checks++; if (s_adr !== 32'h0) begin n_fail++; $display("FAIL reset_s_adr got=%h exp=0", s_adr); end
    n_checks++; if (m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat_o got=%h/%h exp=0", m0_dat_o, m1_dat_o); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    $display("txn reset: outputs held low during reset");
  endtask

  task automatic test_single();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h8000_0000; m0_sel = 4'hF; m1_cyc = 0;
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL single_pre_grant got=%b exp=00", grant); end
    @(negedge clk); #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant got=%b exp=01", grant); end
    n_checks++; if (s_adr !== 32'h8000_0000 || s_cyc !== 1'b1 || s_sel !== 4'hF) begin n_fail++; $display("FAIL single_route got adr=%h cyc=%b sel=%h exp 80000000/1/f", s_adr, s_cyc, s_sel); end
    n_checks++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL single_no_ack_yet got=%b exp=0", m0_ack); end
    @(negedge clk);
    s_ack = 1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (m0_ack !== 1'b1 || m0_dat_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_ack got ack=%b dat=%h exp 1/deadbeef", m0_ack, m0_dat_o); end
    n_checks++; if (m1_ack !== 1'b0) begin n_fail++; $display("FAIL single_m1_ack got=%b exp=0", m1_ack); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk); #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL single_release got=%b exp=00", grant); end
    $display("txn single: m0 read 0x80000000 -> deadbeef");
  endtask

  task automatic test_contention();
    rst = 1'b1; #2; rst = 1'b0;
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA000_0000;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB000_0000;
    @(negedge clk);
    s_ack = 1;
    #1;
    n_checks++; if (grant !== 2'b01 || s_adr !== 32'hA000_0000) begin n_fail++; $display("FAIL tie1_grant got=%b adr=%h exp 01/a0000000", grant, s_adr); end
    n_checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin n_fail++; $display("FAIL tie1_ack got m0=%b m1=%b exp 1/0", m0_ack, m1_ack); end
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1;
    n_checks++; if (grant !== 2'b01 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL handover_hold got grant=%b cyc=%b exp 01/0", grant, s_cyc); end
    @(negedge clk);
    s_ack = 1;
    #1;
    n_checks++; if (grant !== 2'b10 || s_adr !== 32'hB000_0000) begin n_fail++; $display("FAIL handover_m1 got=%b adr=%h exp 10/b0000000", grant, s_adr); end
    n_checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin n_fail++; $display("FAIL handover_ack got m1=%b m0=%b exp 1/0", m1_ack, m0_ack); end
    @(negedge clk);
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    @(negedge clk); #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tie_idle got=%b exp=00", grant); end
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    @(negedge clk); #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL tie2_grant got=%b exp=01", grant); end
    settle_idle();
    $display("txn contention: m0, m1, then m0 on second tie");
  endtask

  task automatic test_lock();
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'hC000_0010; m1_dat = 32'h5555_AAAA;
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1;
    for (int t = 0; t < 3; t++) begin
      s_ack = 0;
      @(negedge clk);
      s_ack = 1;
      #1;
      n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL lock_grant t=%0d got=%b exp=10", t, grant); end
      n_checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin n_fail++; $display("FAIL lock_ack t=%0d got m1=%b m0=%b exp 1/0", t, m1_ack, m0_ack); end
      n_checks++; if (s_we !== 1'b1 || s_dat_o !== 32'h5555_AAAA) begin n_fail++; $display("FAIL lock_wdata t=%0d got we=%b dat=%h", t, s_we, s_dat_o); end
      @(negedge clk);
      $display("txn lock: m1 write %0d acked", t);
    end
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    @(negedge clk); #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL lock_release got=%b exp=01", grant); end
    settle_idle();
  endtask

  task automatic test_timeout();
    logic expf;
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h4000_0000;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      expf = (c == 5);
      n_checks++; if (m0_err !== expf || timeout !== expf) begin n_fail++; $display("FAIL wd_fire c=%0d got err=%b to=%b exp=%b", c, m0_err, timeout, expf); end
      n_checks++; if (s_stb !== !expf || s_cyc !== !expf) begin n_fail++; $display("FAIL wd_abort c=%0d got stb=%b cyc=%b exp=%b", c, s_stb, s_cyc, !expf); end
      n_checks++; if (z_m0_err !== 1'b0 || z_timeout !== 1'b0 || z_s_stb !== 1'b1) begin n_fail++; $display("FAIL nowd_stall c=%0d got err=%b to=%b stb=%b exp 0/0/1", c, z_m0_err, z_timeout, z_s_stb); end
    end
    @(negedge clk); #1;
    n_checks++; if (timeout !== 1'b0 || grant !== 2'b01 || s_stb !== 1'b1) begin n_fail++; $display("FAIL wd_after got to=%b grant=%b stb=%b exp 0/01/1", timeout, grant, s_stb); end
    settle_idle();
    $display("txn timeout: m0 stalled, err after 5 cycles");
  endtask

  task automatic test_ack_at_limit();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h4000_0004;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 5) begin s_ack = 1; s_dat_i = 32'h0BAD_F00D; end
      #1;
    end
    n_checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL ack_at_limit got ack=%b err=%b to=%b exp 1/0/0", m0_ack, m0_err, timeout); end
    n_checks++; if (s_stb !== 1'b1) begin n_fail++; $display("FAIL ack_at_limit_stb got=%b exp=1", s_stb); end
    settle_idle();
    $display("txn ack_at_limit: ack wins over timeout");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'hD000_0000;
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; s_ack = 1; s_dat_i = 32'hCAFE_0001;
    #1;
    n_checks++; if (grant !== 2'b10 || m1_ack !== 1'b1) begin n_fail++; $display("FAIL mid_pre got grant=%b ack=%b exp 10/1", grant, m1_ack); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (grant !== 2'b00 || s_cyc !== 1'b0 || s_adr !== 32'h0) begin n_fail++; $display("FAIL mid_rst got grant=%b cyc=%b adr=%h exp 00/0/0", grant, s_cyc, s_adr); end
    n_checks++; if (m1_ack !== 1'b0 || m1_dat_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_resp got ack=%b dat=%h exp 0/0", m1_ack, m1_dat_o); end
    @(negedge clk);
    rst = 1'b0; s_ack = 0;
    @(negedge clk); #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL mid_tie got=%b exp=01", grant); end
    settle_idle();
    $display("txn reset_mid: m1 aborted, m0 wins next tie");
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
